// File: rtl/sram_arbiter_pkg.sv
// Shared AXI/SRAM definitions for the two-port SRAM arbiter: ownership FSM
// states and the "no byte written" strobe pattern of the macro.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } arb_state_e;

    localparam logic [3:0] WEB_NONE = 4'hF;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that did not fire last (rr) wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = rr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one single-port SRAM macro with optional
// ownership locking, an idle-timeout lock release and one-cycle read responses.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LOCK_TO = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0]             req_lock,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]       req_wdata,
    input  logic [1:0][3:0]        req_wstrb,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic [ADDR_W-1:0]      sram_A,
    output logic [31:0]            sram_DI,
    output logic [3:0]             sram_WEB,
    input  logic [31:0]            sram_DO
);

    // The counter saturates one short of LOCK_TO so a 4-bit register covers 16.
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_TO - 1);

    arb_state_e state;
    logic       rr;
    logic [3:0] idle_cnt;
    logic [1:0] rsp_pend;
    logic [1:0] arb_grant;
    logic [1:0] fire;
    logic       fire_any;
    logic       fire_idx;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .rr    (rr),
        .grant (arb_grant)
    );

    always_comb begin
        req_ready = 2'b00;
        if (ARESETn) begin
            case (state)
                UNLOCKED: req_ready = arb_grant;
                OWN0:     req_ready = {1'b0, req_valid[0]};
                OWN1:     req_ready = {req_valid[1], 1'b0};
                default:  req_ready = 2'b00;
            endcase
        end
    end

    assign fire     = req_valid & req_ready;
    assign fire_any = |fire;
    assign fire_idx = fire[1];

    always_comb begin
        sram_A   = '0;
        sram_DI  = '0;
        sram_WEB = WEB_NONE;
        if (fire_any) begin
            sram_A = req_addr[fire_idx];
            if (req_we[fire_idx]) begin
                sram_DI  = req_wdata[fire_idx];
                sram_WEB = ~req_wstrb[fire_idx];
            end
        end
    end

    // Ownership FSM, round-robin pointer, idle timeout and read-response tracking.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= UNLOCKED;
            rr       <= 1'b0;
            idle_cnt <= 4'd0;
            rsp_pend <= 2'b00;
        end else begin
            rsp_pend <= fire & ~req_we;
            if (fire_any) begin
                rr <= fire_idx;
            end
            case (state)
                UNLOCKED: begin
                    idle_cnt <= 4'd0;
                    if (fire_any && req_lock[fire_idx]) begin
                        state <= fire_idx ? OWN1 : OWN0;
                    end
                end
                OWN0, OWN1: begin
                    if (fire_any) begin
                        idle_cnt <= 4'd0;
                        if (!req_lock[fire_idx]) begin
                            state <= UNLOCKED;
                        end
                    end else if (idle_cnt == LOCK_LAST) begin
                        idle_cnt <= 4'd0;
                        state    <= UNLOCKED;
                    end else begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
                end
                default: begin
                    idle_cnt <= 4'd0;
                    state    <= UNLOCKED;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_pend;
    assign rsp_rdata = (|rsp_pend) ? sram_DO : 32'd0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM macro
// (one-cycle read latency, per-byte active-low write enables).
module tb_sram_arbiter;

    import sram_arbiter_pkg::*;

    localparam int ADDR_W = 14;

    logic                   ACLK;
    logic                   ARESETn;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [1:0]             req_lock;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][31:0]       req_wdata;
    logic [1:0][3:0]        req_wstrb;
    logic [1:0]             rsp_valid;
    logic [31:0]            rsp_rdata;
    logic [ADDR_W-1:0]      sram_A;
    logic [31:0]            sram_DI;
    logic [3:0]             sram_WEB;
    logic [31:0]            sram_DO;

    logic [31:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    sram_arbiter #(
        .ADDR_W  (ADDR_W),
        .LOCK_TO (16)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_A    (sram_A),
        .sram_DI   (sram_DI),
        .sram_WEB  (sram_WEB),
        .sram_DO   (sram_DO)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // SRAM macro model: read-before-write, data out one cycle after the address.
    always @(posedge ACLK) begin
        for (int b = 0; b < 4; b++) begin
            if (!sram_WEB[b]) mem[sram_A[7:0]][8*b +: 8] <= sram_DI[8*b +: 8];
        end
        sram_DO <= mem[sram_A[7:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                                 input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [3:0] s0, input logic [3:0] s1);
        req_valid    = v;
        req_we       = we;
        req_lock     = lk;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        req_wstrb[0] = s0;
        req_wstrb[1] = s1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  grants [4];
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd;
        grants[0] = 2'b10; grants[1] = 2'b01; grants[2] = 2'b10; grants[3] = 2'b01;

        // Reset holds ready low even with both requesters valid.
        ARESETn = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 14'h10, 14'h20, 32'd0, 32'd0, 4'h0, 4'h0);
        @(negedge ACLK); #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_web", 32'(sram_WEB), 32'hF);

        // Preload memory through the arbiter with full-strobe writes.
        @(negedge ACLK); ARESETn = 1'b1;
        applyStimulus(2'b01, 2'b01, 2'b00, 14'h10, 14'h0, 32'hDEADBEEF, 32'd0, 4'hF, 4'h0);
        #1;
        checkOutput("pre_ready0", 32'(req_ready), 32'd1);
        checkOutput("pre_web0", 32'(sram_WEB), 32'h0);
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b01, 2'b00, 14'h20, 14'h0, 32'hFFFFFFFF, 32'd0, 4'hF, 4'h0);
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b01, 2'b00, 14'h30, 14'h0, 32'hA0A0A0A0, 32'd0, 4'hF, 4'h0);
        @(negedge ACLK);
        applyStimulus(2'b10, 2'b10, 2'b00, 14'h0, 14'h40, 32'd0, 32'hB1B1B1B1, 4'h0, 4'hF);
        #1;
        checkOutput("pre_ready1", 32'(req_ready), 32'd2);
        checkOutput("pre_addr1", 32'(sram_A), 32'h40);
        checkOutput("pre_di1", sram_DI, 32'hB1B1B1B1);

        // Single read: same-cycle grant, response one cycle later.
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b00, 2'b00, 14'h10, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("rd_ready", 32'(req_ready), 32'd1);
        checkOutput("rd_addr", 32'(sram_A), 32'h10);
        checkOutput("rd_web", 32'(sram_WEB), 32'hF);
        checkOutput("rd_rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge ACLK);
        applyStimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_data", rsp_rdata, 32'hDEADBEEF);
        @(negedge ACLK); #1;
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_rdata", rsp_rdata, 32'd0);
        checkOutput("idle_addr", 32'(sram_A), 32'd0);
        checkOutput("idle_di", sram_DI, 32'd0);
        checkOutput("idle_web", 32'(sram_WEB), 32'hF);

        // Locked read, then a reset pulse right after it fires.
        applyStimulus(2'b01, 2'b00, 2'b01, 14'h10, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("lkrd_ready", 32'(req_ready), 32'd1);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 14'h30, 14'h40, 32'd0, 32'd0, 4'h0, 4'h0);
        @(negedge ACLK); #1;
        checkOutput("rstp_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rstp_ready", 32'(req_ready), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Contention after reset alternates 1,0,1,0.
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rv = (k == 0) ? 2'b00 : grants[k-1];
            exp_rd = (exp_rv == 2'b01) ? 32'hA0A0A0A0 : (exp_rv == 2'b10) ? 32'hB1B1B1B1 : 32'd0;
            checkOutput($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(grants[k]));
            checkOutput($sformatf("rr_rsp_valid%0d", k), 32'(rsp_valid), 32'(exp_rv));
            checkOutput($sformatf("rr_rsp_data%0d", k), rsp_rdata, exp_rd);
            @(negedge ACLK);
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("rr_rsp_valid_last", 32'(rsp_valid), 32'd1);
        checkOutput("rr_rsp_data_last", rsp_rdata, 32'hA0A0A0A0);

        // Partial-strobe write, zero-strobe write, then read back.
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b01, 2'b00, 14'h20, 14'h0, 32'h12345678, 32'd0, 4'b0011, 4'h0);
        #1;
        checkOutput("wr_ready", 32'(req_ready), 32'd1);
        checkOutput("wr_web", 32'(sram_WEB), 32'hC);
        checkOutput("wr_di", sram_DI, 32'h12345678);
        checkOutput("wr_addr", 32'(sram_A), 32'h20);
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b01, 2'b00, 14'h20, 14'h0, 32'h0, 32'd0, 4'b0000, 4'h0);
        #1;
        checkOutput("wr0_web", 32'(sram_WEB), 32'hF);
        checkOutput("wr_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge ACLK);
        applyStimulus(2'b01, 2'b00, 2'b00, 14'h20, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("wr0_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge ACLK);
        applyStimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("wr_rb_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_rb_data", rsp_rdata, 32'hFFFF5678);

        // Make requester 1 the last to fire so requester 0 wins the next tie.
        @(negedge ACLK);
        applyStimulus(2'b10, 2'b00, 2'b00, 14'h0, 14'h40, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("lk_pre_ready", 32'(req_ready), 32'd2);

        // Three locked beats from requester 0 block requester 1.
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            applyStimulus(2'b11, 2'b00, (k < 2) ? 2'b01 : 2'b00, 14'h10, 14'h40,
                          32'd0, 32'd0, 4'h0, 4'h0);
            #1;
            checkOutput($sformatf("lk_beat%0d", k), 32'(req_ready), 32'd1);
        end
        @(negedge ACLK); #1;
        checkOutput("lk_release", 32'(req_ready), 32'd2);
        checkOutput("lk_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("lk_rsp_data", rsp_rdata, 32'hDEADBEEF);

        // Lock, then 16 idle cycles: requester 1 only wins on cycle 17.
        @(negedge ACLK);
        applyStimulus(2'b11, 2'b00, 2'b01, 14'h10, 14'h40, 32'd0, 32'd0, 4'h0, 4'h0);
        #1;
        checkOutput("to_lock", 32'(req_ready), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge ACLK);
            applyStimulus(2'b10, 2'b00, 2'b00, 14'h0, 14'h40, 32'd0, 32'd0, 4'h0, 4'h0);
            #1;
            checkOutput($sformatf("to_hold%0d", k), 32'(req_ready), 32'd0);
        end
        @(negedge ACLK); #1;
        checkOutput("to_release", 32'(req_ready), 32'd2);

        @(negedge ACLK);
        applyStimulus(2'b00, 2'b00, 2'b00, 14'h0, 14'h0, 32'd0, 32'd0, 4'h0, 4'h0);
        @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
